mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares the single combinational Int0 multiplier (32x16 signed, saturation, tag mode) between two issue lanes of Exe0.
- Round-robin arbitration accepts one command per cycle into an operand register that drives the multiplier.
- The multiplier result is captured into a result register and returned with the winning lane's ID under a valid/ready handshake.
- Two-stage pipeline with full backpressure; throughput is 1 op/cycle.

Parameters:
- PRIO_INIT, 0, lane holding priority after reset (0 or 1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_i_marb  in  2  per-lane request; lane n holds req and cmd stable until ack[n]
- cmd_i_marb  in  160  lane n command at [80n+79:80n]. Fields: opr0[79:48], opr1[47:32], imm16[31:16], gen[15:4], tag[3], sat[2], r_sel[1], imm_sel[0]
- ack_o_marb  out  2  one-hot; command of that lane accepted this cycle (combinational)
- mul_opr0_o_marb  out  32  to multiplier opr0
- mul_opr1_o_marb  out  16  to multiplier opr1
- mul_imm16_o_marb  out  16  to multiplier imm16
- mul_gen_o_marb  out  12  to multiplier gen
- mul_ctl_o_marb  out  4  {tag, sat, r_sel, imm_sel} to multiplier
- mul_rslt_i_marb  in  32  multiplier result
- mul_cc_i_marb  in  2  multiplier condition code
- mul_tag_i_marb  in  12  multiplier result tag
- rslt_vld_o_marb  out  1  result register valid
- rslt_rdy_i_marb  in  1  consumer ready
- rslt_o_marb  out  32  result
- rslt_cc_o_marb  out  2  condition code
- rslt_tag_o_marb  out  12  result tag
- rslt_id_o_marb  out  1  originating lane
- busy_o_marb  out  1  any op in flight

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset effects: s1_vld=0, s2_vld=0, prio=PRIO_INIT. All registered data outputs clear to 0; rslt_vld=0; busy=0. In-flight ops are discarded silently; a pending req is not acked during the reset cycle.
- Stage S1 (operand register) drives the mul_* outputs directly. Fields are passed bit-exact; the arbiter does no arithmetic.
- s2_adv = s2_vld & rslt_rdy.
- s1_adv = s1_vld & (~s2_vld | rslt_rdy).
- s1_load_ok = ~s1_vld | s1_adv.
- Grant, when s1_load_ok:
  - only one req bit set: that lane wins.
  - both set: lane == prio wins; prio then flips to the loser.
  - single-lane grant: prio := ~winner.
  - no req or ~s1_load_ok: no ack, prio unchanged.
- On grant: ack[winner]=1 in the same cycle. S1 captures the cmd fields and ID at the clock edge; s1_vld := 1.
- On s1_adv: S2 captures mul_rslt/cc/tag and the S1 ID; s2_vld := 1.
- If s1_adv occurs without a grant: s1_vld := 0.
- If s2_adv occurs without s1_adv: s2_vld := 0.
- rslt_vld = s2_vld. S2 data holds stable while rslt_vld & ~rslt_rdy.
- Latency: ack at cycle t gives rslt_vld at t+2 when there is no backpressure.
- Full pipe (s1_vld & s2_vld & ~rslt_rdy): no ack; both stages hold.
- Simultaneous drain and accept at full pipe with rslt_rdy=1: S2 gets the S1 op, S1 gets the new op, and the new op is acked the same cycle.
- busy = s1_vld | s2_vld.
- Lane 1 fields are never routed with lane 0's ID: ID and data are captured together.
- req without a later ack may be withdrawn; the arbiter tolerates this with no state change.

Test Plan:
- Reset, PRIO_INIT=0, both req every cycle, rslt_rdy=1:
  - Required acks alternate 01,10,01,10.
  - rslt_id sequence 0,1,0,1 starting 2 cycles after the first ack.
- Lane 0 only, opr0=0x0000_1234, opr1=0x0010, ctl=0000, mul model stubbed with the true product:
  - ack[0] at t; rslt_vld at t+2 with rslt=0x0001_2340, id=0.
  - busy high for t+1..t+2.
- Backpressure: rslt_rdy=0 after first result, both lanes requesting:
  - exactly one more ack, then no acks.
  - rslt_* stable for 5 cycles.
  - rslt_rdy=1 gives 2 results on consecutive cycles and acks resume in the same cycle.
- Full pipe with rslt_rdy=1 and req[1]:
  - ack[1] in the same cycle S2 drains.
  - no bubble in rslt_vld.
- rst asserted for 1 cycle with both stages full:
  - next cycle rslt_vld=0, busy=0, prio=PRIO_INIT.
  - no stale result appears afterwards.
- PRIO_INIT=1, simultaneous first req from both lanes:
  - first ack=10, then prio=0.
  - a lane-0-only req then acks 01.

Source files
------------

// File: rtl/mul_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_arbiter_if                                                             |
// | Bundle between the two Exe0 issue lanes, the shared Int0 multiplier and    |
// | the result consumer.                                                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mul_arbiter_if;
    logic [1:0]   req_i_marb;
    logic [159:0] cmd_i_marb;
    logic [1:0]   ack_o_marb;
    logic [31:0]  mul_opr0_o_marb;
    logic [15:0]  mul_opr1_o_marb;
    logic [15:0]  mul_imm16_o_marb;
    logic [11:0]  mul_gen_o_marb;
    logic [3:0]   mul_ctl_o_marb;
    logic [31:0]  mul_rslt_i_marb;
    logic [1:0]   mul_cc_i_marb;
    logic [11:0]  mul_tag_i_marb;
    logic         rslt_vld_o_marb;
    logic         rslt_rdy_i_marb;
    logic [31:0]  rslt_o_marb;
    logic [1:0]   rslt_cc_o_marb;
    logic [11:0]  rslt_tag_o_marb;
    logic         rslt_id_o_marb;
    logic         busy_o_marb;

    // Environment side: issue lanes, multiplier and result consumer
    modport master (
        output req_i_marb, cmd_i_marb, mul_rslt_i_marb, mul_cc_i_marb,
               mul_tag_i_marb, rslt_rdy_i_marb,
        input  ack_o_marb, mul_opr0_o_marb, mul_opr1_o_marb, mul_imm16_o_marb,
               mul_gen_o_marb, mul_ctl_o_marb, rslt_vld_o_marb, rslt_o_marb,
               rslt_cc_o_marb, rslt_tag_o_marb, rslt_id_o_marb, busy_o_marb
    );

    modport slave (
        input  req_i_marb, cmd_i_marb, mul_rslt_i_marb, mul_cc_i_marb,
               mul_tag_i_marb, rslt_rdy_i_marb,
        output ack_o_marb, mul_opr0_o_marb, mul_opr1_o_marb, mul_imm16_o_marb,
               mul_gen_o_marb, mul_ctl_o_marb, rslt_vld_o_marb, rslt_o_marb,
               rslt_cc_o_marb, rslt_tag_o_marb, rslt_id_o_marb, busy_o_marb
    );
endinterface
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_arbiter                                                                |
// | Round-robin share of the Int0 multiplier between two lanes; operand and    |
// | result registers form a two-stage pipe with full backpressure.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mul_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mul_arbiter_if.slave bus
);
    localparam logic c_PRIO_INIT = PRIO_INIT[0];

    logic        r_s1_vld;
    logic        r_s1_id;
    logic [31:0] r_s1_opr0;
    logic [15:0] r_s1_opr1;
    logic [15:0] r_s1_imm16;
    logic [11:0] r_s1_gen;
    logic [3:0]  r_s1_ctl;

    logic        r_s2_vld;
    logic        r_s2_id;
    logic [31:0] r_s2_rslt;
    logic [1:0]  r_s2_cc;
    logic [11:0] r_s2_tag;

    logic        r_prio;

    logic        w_s1_adv;
    logic        w_s2_adv;
    logic        w_s1_load_ok;
    logic        w_grant;
    logic        w_winner;
    logic [79:0] w_cmd;

    assign w_s2_adv     = r_s2_vld & bus.rslt_rdy_i_marb;
    assign w_s1_adv     = r_s1_vld & (~r_s2_vld | bus.rslt_rdy_i_marb);
    assign w_s1_load_ok = ~r_s1_vld | w_s1_adv;

    // Grant is suppressed while rst is high so no request is acked and lost
    always_comb begin
        w_grant  = 1'b0;
        w_winner = 1'b0;
        if (!rst && w_s1_load_ok) begin
            case (bus.req_i_marb)
                2'b01: begin
                    w_grant  = 1'b1;
                    w_winner = 1'b0;
                end
                2'b10: begin
                    w_grant  = 1'b1;
                    w_winner = 1'b1;
                end
                2'b11: begin
                    w_grant  = 1'b1;
                    w_winner = r_prio;
                end
                default: begin
                    w_grant  = 1'b0;
                    w_winner = 1'b0;
                end
            endcase
        end
    end

    assign w_cmd          = w_winner ? bus.cmd_i_marb[159:80] : bus.cmd_i_marb[79:0];
    assign bus.ack_o_marb = {w_grant & w_winner, w_grant & ~w_winner};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_opr0  <= 32'd0;
            r_s1_opr1  <= 16'd0;
            r_s1_imm16 <= 16'd0;
            r_s1_gen   <= 12'd0;
            r_s1_ctl   <= 4'd0;
            r_s2_vld   <= 1'b0;
            r_s2_id    <= 1'b0;
            r_s2_rslt  <= 32'd0;
            r_s2_cc    <= 2'd0;
            r_s2_tag   <= 12'd0;
            r_prio     <= c_PRIO_INIT;
        end else begin
            // The winner's ID is captured alongside its fields, keeping them paired
            if (w_grant) begin
                r_s1_vld   <= 1'b1;
                r_s1_id    <= w_winner;
                r_s1_opr0  <= w_cmd[79:48];
                r_s1_opr1  <= w_cmd[47:32];
                r_s1_imm16 <= w_cmd[31:16];
                r_s1_gen   <= w_cmd[15:4];
                r_s1_ctl   <= w_cmd[3:0];
                r_prio     <= ~w_winner;
            end else if (w_s1_adv) begin
                r_s1_vld <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_vld  <= 1'b1;
                r_s2_id   <= r_s1_id;
                r_s2_rslt <= bus.mul_rslt_i_marb;
                r_s2_cc   <= bus.mul_cc_i_marb;
                r_s2_tag  <= bus.mul_tag_i_marb;
            end else if (w_s2_adv) begin
                r_s2_vld <= 1'b0;
            end
        end
    end

    assign bus.mul_opr0_o_marb  = r_s1_opr0;
    assign bus.mul_opr1_o_marb  = r_s1_opr1;
    assign bus.mul_imm16_o_marb = r_s1_imm16;
    assign bus.mul_gen_o_marb   = r_s1_gen;
    assign bus.mul_ctl_o_marb   = r_s1_ctl;

    assign bus.rslt_vld_o_marb  = r_s2_vld;
    assign bus.rslt_o_marb      = r_s2_rslt;
    assign bus.rslt_cc_o_marb   = r_s2_cc;
    assign bus.rslt_tag_o_marb  = r_s2_tag;
    assign bus.rslt_id_o_marb   = r_s2_id;
    assign bus.busy_o_marb      = r_s1_vld | r_s2_vld;
endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_arbiter                                                             |
// | Self-checking bench for mul_arbiter against a queue-based reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mul_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_arbiter_if bus0 ();
    mul_arbiter_if bus1 ();

    mul_arbiter #(.PRIO_INIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mul_arbiter #(.PRIO_INIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp  = 0;
    int n_fail = 0;

    // Multiplier stand-in: true signed product, perturbed by imm16/ctl so field routing shows
    function automatic logic [45:0] stub(input logic [31:0] a, input logic [15:0] b,
                                         input logic [15:0] imm, input logic [11:0] gen,
                                         input logic [3:0] ctl);
        logic signed [63:0] full;
        logic [31:0] p;
        full = $signed(a) * $signed(b);
        p    = full[31:0] ^ {imm, 12'h000, ctl};
        return {p[1:0] ^ ctl[3:2], gen ^ {8'h00, ctl}, p};
    endfunction

    assign {bus0.mul_cc_i_marb, bus0.mul_tag_i_marb, bus0.mul_rslt_i_marb} =
        stub(bus0.mul_opr0_o_marb, bus0.mul_opr1_o_marb, bus0.mul_imm16_o_marb,
             bus0.mul_gen_o_marb, bus0.mul_ctl_o_marb);
    assign {bus1.mul_cc_i_marb, bus1.mul_tag_i_marb, bus1.mul_rslt_i_marb} =
        stub(bus1.mul_opr0_o_marb, bus1.mul_opr1_o_marb, bus1.mul_imm16_o_marb,
             bus1.mul_gen_o_marb, bus1.mul_ctl_o_marb);

    function automatic logic [45:0] lane_res(input logic [159:0] cmd, input logic lane);
        logic [79:0] c;
        c = lane ? cmd[159:80] : cmd[79:0];
        return stub(c[79:48], c[47:32], c[31:16], c[15:4], c[3:0]);
    endfunction

    function automatic logic [79:0] rand80();
        return {32'($urandom), 16'($urandom), 16'($urandom), 12'($urandom), 4'($urandom)};
    endfunction

    // ---------------- reference model (dut0) ----------------
    // Ops in flight, oldest first; stage 2 means the op sits at the result output.
    typedef struct {
        logic [45:0] res;
        logic        id;
        int          stage;
    } ent_t;
    ent_t mq[$];
    logic m_prio = 1'b0;

    function automatic logic [1:0] model_ack();
        logic [1:0] r;
        r = bus0.req_i_marb;
        if (rst) return 2'b00;
        if (!(mq.size() < 2 || bus0.rslt_rdy_i_marb)) return 2'b00;
        if (r == 2'b11) return m_prio ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic model_vld();
        return (mq.size() > 0) && (mq[0].stage == 2);
    endfunction

    always @(posedge clk) begin
        logic [1:0] a;
        ent_t e;
        a = model_ack();
        if (rst) begin
            mq.delete();
            m_prio = 1'b0;
        end else begin
            if (model_vld() && bus0.rslt_rdy_i_marb) void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].stage == 1) begin
                e = mq[0];
                e.stage = 2;
                mq[0] = e;
            end
            if (a != 2'b00) begin
                e.id    = a[1];
                e.res   = lane_res(bus0.cmd_i_marb, a[1]);
                e.stage = 1;
                mq.push_back(e);
                m_prio = ~a[1];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle(input logic [1:0] acked);
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++)
            if (acked[l]) bus0.cmd_i_marb[l*80 +: 80] = rand80();
    endtask

    task automatic idle(input int n);
        bus0.req_i_marb      = 2'b00;
        bus0.rslt_rdy_i_marb = 1'b1;
        repeat (n) next_cycle(2'b00);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus0.req_i_marb = 2'b11;
        repeat (2) next_cycle(2'b00);
        @(negedge clk);
        n_cmp++; if (bus0.ack_o_marb !== 2'b00) begin n_fail++; $display("FAIL reset_ack got=%b exp=00", bus0.ack_o_marb); end
        n_cmp++; if (bus0.rslt_vld_o_marb !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", bus0.rslt_vld_o_marb); end
        n_cmp++; if (bus0.busy_o_marb !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus0.busy_o_marb); end
        n_cmp++; if (bus0.rslt_o_marb !== 32'd0) begin n_fail++; $display("FAIL reset_rslt got=%h exp=0", bus0.rslt_o_marb); end
        n_cmp++; if (bus0.mul_opr0_o_marb !== 32'd0) begin n_fail++; $display("FAIL reset_opr0 got=%h exp=0", bus0.mul_opr0_o_marb); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus0.req_i_marb = 2'b00;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_ack;
        bus0.req_i_marb      = 2'b11;
        bus0.rslt_rdy_i_marb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_ack = (c % 2) ? 2'b10 : 2'b01;
            n_cmp++; if (bus0.ack_o_marb !== exp_ack) begin n_fail++; $display("FAIL alt_ack cyc=%0d got=%b exp=%b", c, bus0.ack_o_marb, exp_ack); end
            n_cmp++; if (bus0.rslt_vld_o_marb !== (c >= 2)) begin n_fail++; $display("FAIL alt_vld cyc=%0d got=%b exp=%b", c, bus0.rslt_vld_o_marb, c >= 2); end
            if (c >= 2) begin
                n_cmp++; if (bus0.rslt_id_o_marb !== logic'(c % 2)) begin n_fail++; $display("FAIL alt_id cyc=%0d got=%b exp=%0d", c, bus0.rslt_id_o_marb, c % 2); end
                n_cmp++; if (model_vld() && {bus0.rslt_cc_o_marb, bus0.rslt_tag_o_marb, bus0.rslt_o_marb} !== mq[0].res) begin n_fail++; $display("FAIL alt_data cyc=%0d got=%h exp=%h", c, bus0.rslt_o_marb, mq[0].res[31:0]); end
            end
            next_cycle(bus0.ack_o_marb);
        end
        idle(3);
    endtask

    task automatic test_single();
        bus0.cmd_i_marb[79:0] = {32'h0000_1234, 16'h0010, 16'h0000, 12'h5A5, 4'h0};
        bus0.req_i_marb = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus0.ack_o_marb !== 2'b01) begin n_fail++; $display("FAIL single_ack got=%b exp=01", bus0.ack_o_marb); end
        next_cycle(bus0.ack_o_marb);
        bus0.req_i_marb = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus0.busy_o_marb !== 1'b1 || bus0.rslt_vld_o_marb !== 1'b0) begin n_fail++; $display("FAIL single_t1 busy=%b vld=%b exp busy=1 vld=0", bus0.busy_o_marb, bus0.rslt_vld_o_marb); end
        n_cmp++; if (bus0.mul_opr0_o_marb !== 32'h0000_1234 || bus0.mul_opr1_o_marb !== 16'h0010) begin n_fail++; $display("FAIL single_opr got=%h/%h exp=00001234/0010", bus0.mul_opr0_o_marb, bus0.mul_opr1_o_marb); end
        next_cycle(2'b00);
        @(negedge clk);
        n_cmp++; if (bus0.rslt_vld_o_marb !== 1'b1 || bus0.busy_o_marb !== 1'b1) begin n_fail++; $display("FAIL single_t2 vld=%b busy=%b exp 1/1", bus0.rslt_vld_o_marb, bus0.busy_o_marb); end
        n_cmp++; if (bus0.rslt_o_marb !== 32'h0001_2340) begin n_fail++; $display("FAIL single_rslt got=%h exp=00012340", bus0.rslt_o_marb); end
        n_cmp++; if (bus0.rslt_id_o_marb !== 1'b0 || bus0.rslt_tag_o_marb !== 12'h5A5) begin n_fail++; $display("FAIL single_id_tag got=%b/%h exp=0/5a5", bus0.rslt_id_o_marb, bus0.rslt_tag_o_marb); end
        next_cycle(2'b00);
        @(negedge clk);
        n_cmp++; if (bus0.busy_o_marb !== 1'b0) begin n_fail++; $display("FAIL single_t3_busy got=%b exp=0", bus0.busy_o_marb); end
        idle(2);
    endtask

    task automatic test_backpressure();
        int n_acks = 0;
        bus0.req_i_marb = 2'b11;
        for (int c = 0; c < 12; c++) begin
            bus0.rslt_rdy_i_marb = !(c >= 1 && c < 10);
            @(negedge clk);
            n_cmp++; if (bus0.ack_o_marb !== model_ack()) begin n_fail++; $display("FAIL bp_ack cyc=%0d got=%b exp=%b", c, bus0.ack_o_marb, model_ack()); end
            if (c >= 1 && c < 10 && bus0.ack_o_marb != 2'b00) n_acks++;
            if (c >= 2) begin
                n_cmp++; if (bus0.rslt_vld_o_marb !== 1'b1) begin n_fail++; $display("FAIL bp_vld cyc=%0d got=%b exp=1", c, bus0.rslt_vld_o_marb); end
                n_cmp++; if (model_vld() && {bus0.rslt_cc_o_marb, bus0.rslt_tag_o_marb, bus0.rslt_id_o_marb, bus0.rslt_o_marb} !== {mq[0].res[45:32], mq[0].id, mq[0].res[31:0]}) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, bus0.rslt_o_marb, mq[0].res[31:0]); end
            end
            if (c == 10) begin
                n_cmp++; if (bus0.ack_o_marb === 2'b00) begin n_fail++; $display("FAIL bp_resume got=%b exp=nonzero", bus0.ack_o_marb); end
            end
            next_cycle(bus0.ack_o_marb);
        end
        n_cmp++; if (n_acks != 1) begin n_fail++; $display("FAIL bp_ack_count got=%0d exp=1", n_acks); end
        idle(4);
    endtask

    task automatic test_full_drain();
        bus0.req_i_marb      = 2'b11;
        bus0.rslt_rdy_i_marb = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            next_cycle(bus0.ack_o_marb);
        end
        bus0.req_i_marb      = 2'b10;
        bus0.rslt_rdy_i_marb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++; if (bus0.ack_o_marb !== 2'b10) begin n_fail++; $display("FAIL drain_ack got=%b exp=10", bus0.ack_o_marb); end
            end
            n_cmp++; if (bus0.rslt_vld_o_marb !== (c < 3)) begin n_fail++; $display("FAIL drain_vld cyc=%0d got=%b exp=%b", c, bus0.rslt_vld_o_marb, c < 3); end
            if (c == 2) begin
                n_cmp++; if (bus0.rslt_id_o_marb !== 1'b1) begin n_fail++; $display("FAIL drain_id got=%b exp=1", bus0.rslt_id_o_marb); end
            end
            next_cycle(bus0.ack_o_marb);
            bus0.req_i_marb = 2'b00;
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        bus0.req_i_marb      = 2'b01;
        bus0.rslt_rdy_i_marb = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            next_cycle(bus0.ack_o_marb);
        end
        bus0.req_i_marb = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus0.busy_o_marb !== 1'b1 || bus0.rslt_vld_o_marb !== 1'b1) begin n_fail++; $display("FAIL mid_full busy=%b vld=%b exp 1/1", bus0.busy_o_marb, bus0.rslt_vld_o_marb); end
        next_cycle(2'b00);
        rst = 1'b1;
        bus0.req_i_marb = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus0.ack_o_marb !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ack got=%b exp=00", bus0.ack_o_marb); end
        next_cycle(2'b00);
        rst = 1'b0;
        bus0.req_i_marb      = 2'b00;
        bus0.rslt_rdy_i_marb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (bus0.rslt_vld_o_marb !== 1'b0 || bus0.busy_o_marb !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc=%0d vld=%b busy=%b exp 0/0", c, bus0.rslt_vld_o_marb, bus0.busy_o_marb); end
            next_cycle(2'b00);
        end
        bus0.req_i_marb = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus0.ack_o_marb !== 2'b01) begin n_fail++; $display("FAIL mid_prio got=%b exp=01", bus0.ack_o_marb); end
        next_cycle(bus0.ack_o_marb);
        idle(3);
    endtask

    task automatic test_random();
        logic [1:0] acked;
        for (int c = 0; c < 300; c++) begin
            bus0.rslt_rdy_i_marb = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_cmp++; if (bus0.ack_o_marb !== model_ack()) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, bus0.ack_o_marb, model_ack()); end
            n_cmp++; if (bus0.rslt_vld_o_marb !== model_vld() || bus0.busy_o_marb !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_vld_busy cyc=%0d got=%b/%b exp=%b/%b", c, bus0.rslt_vld_o_marb, bus0.busy_o_marb, model_vld(), mq.size() > 0); end
            if (model_vld()) begin
                n_cmp++; if ({bus0.rslt_cc_o_marb, bus0.rslt_tag_o_marb, bus0.rslt_o_marb} !== mq[0].res || bus0.rslt_id_o_marb !== mq[0].id) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h id=%b exp=%h id=%b", c, {bus0.rslt_cc_o_marb, bus0.rslt_tag_o_marb, bus0.rslt_o_marb}, bus0.rslt_id_o_marb, mq[0].res, mq[0].id); end
            end
            acked = bus0.ack_o_marb;
            next_cycle(acked);
            for (int l = 0; l < 2; l++) begin
                if (acked[l] || !bus0.req_i_marb[l]) begin
                    bus0.req_i_marb[l] = logic'($urandom_range(0, 1));
                end else if ($urandom_range(0, 7) == 0) begin
                    bus0.req_i_marb[l] = 1'b0;
                    bus0.cmd_i_marb[l*80 +: 80] = rand80();
                end
            end
        end
        idle(4);
    endtask

    task automatic test_prio_init1();
        bus1.rslt_rdy_i_marb = 1'b1;
        bus1.req_i_marb      = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus1.ack_o_marb !== 2'b10) begin n_fail++; $display("FAIL p1_first got=%b exp=10", bus1.ack_o_marb); end
        @(posedge clk);
        #1;
        bus1.req_i_marb = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus1.ack_o_marb !== 2'b01) begin n_fail++; $display("FAIL p1_second got=%b exp=01", bus1.ack_o_marb); end
        @(posedge clk);
        #1;
        bus1.req_i_marb = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus1.rslt_vld_o_marb !== 1'b1 || bus1.rslt_id_o_marb !== 1'b1) begin n_fail++; $display("FAIL p1_result vld=%b id=%b exp 1/1", bus1.rslt_vld_o_marb, bus1.rslt_id_o_marb); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        bus0.req_i_marb      = 2'b00;
        bus0.rslt_rdy_i_marb = 1'b1;
        bus0.cmd_i_marb      = {rand80(), rand80()};
        bus1.req_i_marb      = 2'b00;
        bus1.rslt_rdy_i_marb = 1'b1;
        bus1.cmd_i_marb      = {rand80(), rand80()};
        #1;
        test_reset();
        test_alternate();
        test_single();
        test_backpressure();
        test_full_drain();
        test_reset_midflight();
        test_random();
        test_prio_init1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
